ram_ctrl: RTL

//  Responder side of the stage_mem RAM handshake (ram_read/ram_write, ram_busy, ram_ready).

---
 rtl/ram_ctrl_pkg.sv | 22 ++
 rtl/ram_ctrl_ext.sv | 29 ++
 rtl/ram_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the byte-serial RAM controller: length codes, FSM states
// and the byte-count decode.
package ram_ctrl_pkg;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Index of the last byte of a transfer; any code other than 1 or 2 is a word.
    function automatic logic [1:0] len_last(input logic [2:0] len);
        case (len)
            LEN_B:   len_last = 2'd0;
            LEN_H:   len_last = 2'd1;
            default: len_last = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/ram_ctrl_ext.sv
// Little-endian byte assembly with sign/zero extension to 32 bits.
module ram_ctrl_ext
    import ram_ctrl_pkg::*;
(
    input  logic [3:0][7:0] i_bytes,
    input  logic [1:0]      i_last,
    input  logic            i_signed,
    output logic [31:0]     o_data
);

    logic w_sign;

    always_comb begin
        w_sign = 1'b0;
        o_data = i_bytes;
        case (i_last)
            2'd0: begin
                w_sign = i_signed & i_bytes[0][7];
                o_data = {{24{w_sign}}, i_bytes[0]};
            end
            2'd1: begin
                w_sign = i_signed & i_bytes[1][7];
                o_data = {{16{w_sign}}, i_bytes[1], i_bytes[0]};
            end
            default: o_data = i_bytes;
        endcase
    end

endmodule

// File: rtl/ram_ctrl.sv
// Responder for the stage_mem RAM handshake: serialises one 1/2/4-byte load or
// store onto a byte-wide synchronous RAM with RD_LAT read latency.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ram_read,
    input  logic                  ram_write,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [31:0]           ram_data_o,
    input  logic [2:0]            ram_length,
    input  logic                  ram_signed,
    output logic                  ram_busy,
    output logic                  ram_ready,
    output logic [31:0]           ram_data_i,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    input  logic [7:0]            mem_din
);

    logic [1:0]        r_state;
    logic [1:0]        r_last;
    logic [1:0]        r_idx;
    logic [1:0]        r_lane;
    logic              r_iss;
    logic              r_signed;
    logic [3:0][7:0]   r_data;
    logic [3:0][7:0]   r_bytes;
    logic [RD_LAT-1:0] r_vld;

    logic              w_iss;
    logic              w_smp;
    logic [RD_LAT:0]   w_pipe;
    logic [1:0]        w_nidx;
    logic [3:0][7:0]   w_bytes;
    logic [31:0]       w_ext;

    // Each issued read address walks down the valid shift; its tail marks the
    // cycle in which that address's byte is on mem_din.
    assign w_iss  = (r_state == ST_RD) && r_iss;
    assign w_pipe = {r_vld, w_iss};
    assign w_smp  = r_vld[RD_LAT-1];
    assign w_nidx = r_idx + 2'd1;

    always_comb begin
        w_bytes = r_bytes;
        if (w_smp)
            w_bytes[r_lane] = mem_din;
    end

    ram_ctrl_ext u_ext (
        .i_bytes  (w_bytes),
        .i_last   (r_last),
        .i_signed (r_signed),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last     <= '0;
            r_idx      <= '0;
            r_lane     <= '0;
            r_iss      <= 1'b0;
            r_signed   <= 1'b0;
            r_data     <= '0;
            r_bytes    <= '0;
            r_vld      <= '0;
            ram_busy   <= 1'b0;
            ram_ready  <= 1'b0;
            ram_data_i <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
        end else begin
            r_vld <= w_pipe[RD_LAT-1:0];
            case (r_state)
                ST_IDLE: begin
                    if (ram_read || ram_write) begin
                        r_last   <= len_last(ram_length);
                        r_signed <= ram_signed;
                        r_data   <= ram_data_o;
                        r_idx    <= '0;
                        r_lane   <= '0;
                        r_bytes  <= '0;
                        mem_a    <= ram_addr;
                        ram_busy <= 1'b1;
                        // Store has priority when both requests are raised.
                        if (ram_write) begin
                            r_state  <= ST_WR;
                            mem_wr   <= 1'b1;
                            mem_dout <= ram_data_o[7:0];
                        end else begin
                            r_state <= ST_RD;
                            r_iss   <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (r_iss) begin
                        if (r_idx == r_last) begin
                            r_iss <= 1'b0;
                        end else begin
                            r_idx <= w_nidx;
                            mem_a <= mem_a + ADDR_WIDTH'(1);
                        end
                    end
                    if (w_smp) begin
                        r_bytes <= w_bytes;
                        r_lane  <= r_lane + 2'd1;
                        if (r_lane == r_last) begin
                            r_state    <= ST_DONE;
                            ram_busy   <= 1'b0;
                            ram_ready  <= 1'b1;
                            ram_data_i <= w_ext;
                        end
                    end
                end
                ST_WR: begin
                    if (r_idx == r_last) begin
                        mem_wr    <= 1'b0;
                        r_state   <= ST_DONE;
                        ram_busy  <= 1'b0;
                        ram_ready <= 1'b1;
                    end else begin
                        r_idx    <= w_nidx;
                        mem_a    <= mem_a + ADDR_WIDTH'(1);
                        mem_dout <= r_data[w_nidx];
                    end
                end
                default: begin
                    ram_ready <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
